fp_issue_ctrl: RTL and testbench
================================

# fp_issue_ctrl

Parametrised issue/writeback controller for the floating-point datapath: accepts OP-FP instructions over a valid/ready handshake, reads operands from an internal NREG×DATA_W register file, and dispatches them to an external, variable-latency FP ALU over a tagged request/response interface. A per-register scoreboard allows multiple operations in flight, with results returning in any order. Structural and RAW/WAW hazards stall issue.

## Interface
Parameters:
- DATA_W, 32, operand/register width
- NREG, 32, register count; power of two, 2..32
- ADDR_W, $clog2(NREG), register index width (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when valid&&ready
- instruction  in  32  [6:0] opcode, [11:7] rd, [19:15] rs1, [24:20] rs2, [31:27] funct; only low ADDR_W bits of register fields used
- load_en  in  1  host preload strobe
- load_addr  in  ADDR_W  preload register
- load_data  in  DATA_W  preload value
- alu_req_valid  out  1  request to ALU
- alu_req_ready  in  1  ALU accepts request
- alu_op  out  4  0 add, 1 sub, 2 mul, 3 div, 4 sqrt, 5 max, 6 min, 7 eq, 8 lt, 9 le
- alu_a, alu_b  out  DATA_W  rs1/rs2 contents (alu_b don't-care for sqrt)
- alu_tag  out  ADDR_W  destination register
- alu_rsp_valid  in  1  result returning; always accepted
- alu_rsp_data  in  DATA_W  result
- alu_rsp_tag  in  ADDR_W  destination register of result
- data_out  out  DATA_W  last written-back result
- data_out_valid  out  1  one-cycle pulse per writeback
- err  out  1  one-cycle pulse on dropped instruction, stray response or rejected preload
- busy  out  1  issue register full or any scoreboard bit set

## Operation
- Issue register (one entry) holds an accepted instruction. instr_ready = !held || (alu_req_valid && alu_req_ready).
- Legal: opcode == 7'b1010011 and funct <= 9. An illegal instruction is accepted, pulses err the following cycle and is dropped; it never reaches the ALU.
- Hazard: pending[rs1] || pending[rd], or pending[rs2] for funct != 4. alu_req_valid = held && legal && !hazard; alu_a/alu_b read the register file combinationally.
- On alu_req handshake, set pending[rd]. Request fields hold stable while alu_req_valid && !alu_req_ready.
- On alu_rsp_valid: if pending[tag], then regs[tag] <= data, clear pending[tag], data_out <= data, and pulse data_out_valid next cycle. If not pending, ignore the response and pulse err.
- Compare results (eq/lt/le) are written as the ALU returns them (32'h1/32'h0 expected); no special handling.
- Preload: load_en writes regs[load_addr] <= load_data unless pending[load_addr]; if pending, ignore the write and pulse err. When a preload and a response target the same register in the same cycle, the response wins and err pulses.
- No bypass. A register whose result arrives in cycle N is readable by issue in cycle N+1.
- Simultaneous issue (set pending[rd]) and response (clear pending[tag]) on different registers: both take effect. They cannot target the same register, because of the rd hazard.

## Timing
- Reset (rst==0 at edge): regs all 0, pending all 0, issue register empty. Outputs: instr_ready=1, alu_req_valid=0, alu_op/alu_a/alu_b/alu_tag=0, data_out=0, data_out_valid=0, err=0, busy=0. Reset mid-operation discards in-flight ops. Responses arriving while rst==0 are ignored; those arriving after reset hit non-pending tags and pulse err.
- Instruction handshake at edge T → alu_req_valid earliest in cycle T+1.
- Response at edge R → register visible, data_out updated and data_out_valid=1 in cycle R+1; a dependent instruction can issue at R+1.
- Throughput: one issue per cycle with no hazards and alu_req_ready=1.
- err and data_out_valid are registered single-cycle pulses.

## Test plan
- Preload r1=32'h3F800000, r2=32'h40000000; add r3,r1,r2 → alu_req cycle after accept with op=0, a=3F800000, b=40000000, tag=3; rsp 32'h40400000 tag 3 → data_out=40400000 with 1-cycle valid pulse, r3 updated.
- mul r4,r1,r2 then add r5,r4,r1 back-to-back, ALU latency 5 → second request withheld until cycle after r4 response; instr_ready low meanwhile.
- Issue div r6 then add r7; respond tag 7 before tag 6 → both written correctly, busy falls after last response.
- Instruction with opcode 7'b0110011, then funct=12 → each accepted, err pulses, no alu_req_valid.
- alu_req_ready held low 4 cycles → alu_op/a/b/tag stable, instr_ready low; stray rsp tag 9 → err pulse, r9 unchanged.
- rst low with two ops in flight → all outputs at reset values, pending cleared; late rsp tag 3 → err pulse, no writeback.

Source files
------------

// File: rtl/fp_issue_if.sv
// Host/ALU-facing signal bundle for the FP issue/writeback controller.
// The controller takes the slave view; the host/ALU side takes the master view.
interface fp_issue_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instruction;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              alu_req_valid;
  logic              alu_req_ready;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [ADDR_W-1:0] alu_tag;
  logic              alu_rsp_valid;
  logic [DATA_W-1:0] alu_rsp_data;
  logic [ADDR_W-1:0] alu_rsp_tag;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              err;
  logic              busy;

  modport master (
    output instr_valid, instruction, load_en, load_addr, load_data,
           alu_req_ready, alu_rsp_valid, alu_rsp_data, alu_rsp_tag,
    input  instr_ready, alu_req_valid, alu_op, alu_a, alu_b, alu_tag,
           data_out, data_out_valid, err, busy
  );

  modport slave (
    input  instr_valid, instruction, load_en, load_addr, load_data,
           alu_req_ready, alu_rsp_valid, alu_rsp_data, alu_rsp_tag,
    output instr_ready, alu_req_valid, alu_op, alu_a, alu_b, alu_tag,
           data_out, data_out_valid, err, busy
  );
endinterface

// File: rtl/fp_issue_ctrl.sv
// FP issue/writeback controller: single-entry issue register, register file,
// per-register scoreboard and tagged out-of-order writeback from an external ALU.
module fp_issue_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned ADDR_W = $clog2(NREG)
) (
  input logic       clk,
  input logic       rst,
  fp_issue_if.slave bus
);

  localparam logic [6:0] OPCODE_FP  = 7'b1010011;
  localparam logic [4:0] FUNCT_MAX  = 5'd9;
  localparam logic [4:0] FUNCT_SQRT = 5'd4;

  typedef struct packed {
    logic [4:0]        funct;
    logic [ADDR_W-1:0] rs2;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rd;
  } entry_t;

  logic              held_q, held_d;
  entry_t            entry_q, entry_d;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              data_out_valid_q, data_out_valid_d;
  logic              err_q, err_d;

  entry_t in_entry;
  logic   in_legal;
  logic   hazard;
  logic   req_valid;
  logic   req_fire;
  logic   accept;
  logic   rsp_hit;
  logic   load_blocked;
  logic   unused_instr_bits;

  // Decode of the offered instruction; only the low ADDR_W bits of register fields matter.
  always_comb begin
    in_entry.funct = bus.instruction[31:27];
    in_entry.rs2   = ADDR_W'(bus.instruction[24:20]);
    in_entry.rs1   = ADDR_W'(bus.instruction[19:15]);
    in_entry.rd    = ADDR_W'(bus.instruction[11:7]);
    in_legal       = (bus.instruction[6:0] == OPCODE_FP) && (bus.instruction[31:27] <= FUNCT_MAX);
  end

  assign unused_instr_bits = ^{bus.instruction[26:25], bus.instruction[14:12]};

  // sqrt has no second source, so rs2 does not participate in its hazard.
  assign hazard = pending_q[entry_q.rs1] || pending_q[entry_q.rd] ||
                  ((entry_q.funct != FUNCT_SQRT) && pending_q[entry_q.rs2]);

  assign req_valid    = held_q && !hazard;
  assign req_fire     = req_valid && bus.alu_req_ready;
  assign accept       = bus.instr_valid && bus.instr_ready;
  assign rsp_hit      = bus.alu_rsp_valid && pending_q[bus.alu_rsp_tag];
  assign load_blocked = pending_q[bus.load_addr] ||
                        (rsp_hit && (bus.alu_rsp_tag == bus.load_addr));

  always_comb begin
    held_d           = held_q;
    entry_d          = entry_q;
    pending_d        = pending_q;
    regs_d           = regs_q;
    data_out_d       = data_out_q;
    data_out_valid_d = 1'b0;
    err_d            = 1'b0;

    if (req_fire) begin
      held_d              = 1'b0;
      pending_d[entry_q.rd] = 1'b1;
    end

    // Illegal instructions are consumed here and never occupy the issue register.
    if (accept) begin
      if (in_legal) begin
        held_d  = 1'b1;
        entry_d = in_entry;
      end else begin
        err_d = 1'b1;
      end
    end

    if (bus.alu_rsp_valid) begin
      if (rsp_hit) begin
        regs_d[bus.alu_rsp_tag]    = bus.alu_rsp_data;
        pending_d[bus.alu_rsp_tag] = 1'b0;
        data_out_d                 = bus.alu_rsp_data;
        data_out_valid_d           = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // A writeback to the same register in the same cycle takes priority over the preload.
    if (bus.load_en) begin
      if (load_blocked) begin
        err_d = 1'b1;
      end else begin
        regs_d[bus.load_addr] = bus.load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      held_q           <= 1'b0;
      entry_q          <= '0;
      pending_q        <= '0;
      regs_q           <= '{default: '0};
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      err_q            <= 1'b0;
    end else begin
      held_q           <= held_d;
      entry_q          <= entry_d;
      pending_q        <= pending_d;
      regs_q           <= regs_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      err_q            <= err_d;
    end
  end

  assign bus.instr_ready    = !held_q || req_fire;
  assign bus.alu_req_valid  = req_valid;
  assign bus.alu_op         = 4'(entry_q.funct);
  assign bus.alu_a          = regs_q[entry_q.rs1];
  assign bus.alu_b          = regs_q[entry_q.rs2];
  assign bus.alu_tag        = entry_q.rd;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.err            = err_q;
  assign bus.busy           = held_q || (|pending_q);

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: directed scenarios plus randomized traffic against a
// queue-based reference model and a random-latency, out-of-order ALU emulator.
module tb_fp_issue_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk;
  logic rst;

  fp_issue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fp_issue_ctrl #(.DATA_W(DATA_W), .NREG(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Stimulus for the upcoming cycle
  logic        d_rst, d_iv, d_load_en, d_rready, d_rsp_valid;
  logic [31:0] d_instr, d_load_data, d_rsp_data;
  logic [4:0]  d_load_addr, d_rsp_tag;

  // Reference model: architectural registers, in-flight destination list, issue slot
  logic [31:0] m_regs [NREG];
  int          m_inflight[$];
  bit          m_slot_v;
  logic [31:0] m_slot;
  logic [31:0] m_dout;
  bit          m_dv, m_err;

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          due;
  } alu_job_t;
  alu_job_t jobs[$];
  int       cyc;
  bit       auto_alu;

  function automatic logic [31:0] enc(input int funct, input int rd, input int rs1, input int rs2);
    return {5'(funct), 2'b00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b1010011};
  endfunction

  function automatic bit pend(input int r);
    foreach (m_inflight[i]) if (m_inflight[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit is_legal(input logic [31:0] w);
    return (w[6:0] == 7'b1010011) && (w[31:27] <= 5'd9);
  endfunction

  function automatic bit exp_req_valid();
    int rd, rs1, rs2, f;
    if (!m_slot_v) return 1'b0;
    rd  = int'(m_slot[11:7]);
    rs1 = int'(m_slot[19:15]);
    rs2 = int'(m_slot[24:20]);
    f   = int'(m_slot[31:27]);
    return !(pend(rs1) || pend(rd) || (f != 4 && pend(rs2)));
  endfunction

  task automatic idle();
    d_rst = 1'b1; d_iv = 1'b0; d_instr = '0;
    d_load_en = 1'b0; d_load_addr = '0; d_load_data = '0;
    d_rready = 1'b1; d_rsp_valid = 1'b0; d_rsp_tag = '0; d_rsp_data = '0;
  endtask

  task automatic drive();
    rst               = d_rst;
    bus.instr_valid   = d_iv;
    bus.instruction   = d_instr;
    bus.load_en       = d_load_en;
    bus.load_addr     = d_load_addr;
    bus.load_data     = d_load_data;
    bus.alu_req_ready = d_rready;
    bus.alu_rsp_valid = d_rsp_valid;
    bus.alu_rsp_tag   = d_rsp_tag;
    bus.alu_rsp_data  = d_rsp_data;
  endtask

  // Advance the model across one clock edge using the stimulus that was applied.
  task automatic model_commit();
    bit fire, rdy, hit, blocked;
    int fire_rd;
    if (!d_rst) begin
      foreach (m_regs[i]) m_regs[i] = '0;
      m_inflight.delete();
      m_slot_v = 1'b0; m_slot = '0; m_dout = '0; m_dv = 1'b0; m_err = 1'b0;
      return;
    end
    fire    = exp_req_valid() && d_rready;
    rdy     = !m_slot_v || fire;
    hit     = d_rsp_valid && pend(int'(d_rsp_tag));
    blocked = pend(int'(d_load_addr)) || (hit && d_rsp_tag == d_load_addr);
    fire_rd = int'(m_slot[11:7]);
    m_dv  = 1'b0;
    m_err = 1'b0;
    if (d_rsp_valid) begin
      if (hit) begin
        m_regs[d_rsp_tag] = d_rsp_data;
        for (int i = 0; i < m_inflight.size(); i++)
          if (m_inflight[i] == int'(d_rsp_tag)) begin m_inflight.delete(i); break; end
        m_dout = d_rsp_data;
        m_dv   = 1'b1;
      end else begin
        m_err = 1'b1;
      end
    end
    if (d_load_en) begin
      if (blocked) m_err = 1'b1;
      else         m_regs[d_load_addr] = d_load_data;
    end
    if (fire) begin
      m_inflight.push_back(fire_rd);
      m_slot_v = 1'b0;
      if (auto_alu) jobs.push_back('{tag: fire_rd, data: $urandom, due: cyc + int'($urandom_range(1, 6))});
    end
    if (d_iv && rdy) begin
      if (is_legal(d_instr)) begin m_slot_v = 1'b1; m_slot = d_instr; end
      else m_err = 1'b1;
    end
  endtask

  // Called at posedge+1: apply stimulus, compare outputs, cross the next edge.
  task automatic step();
    bit rv;
    drive();
    #1;
    rv = exp_req_valid();
    check_eq("instr_ready", bus.instr_ready, !m_slot_v || (rv && d_rready));
    check_eq("alu_req_valid", bus.alu_req_valid, rv);
    check_eq("busy", bus.busy, m_slot_v || (m_inflight.size() != 0));
    check_eq("data_out_valid", bus.data_out_valid, m_dv);
    check_eq("err", bus.err, m_err);
    check_eq("data_out", bus.data_out, m_dout);
    if (rv) begin
      check_eq("alu_op", bus.alu_op, m_slot[30:27]);
      check_eq("alu_a", bus.alu_a, m_regs[m_slot[19:15]]);
      check_eq("alu_tag", bus.alu_tag, m_slot[11:7]);
      if (m_slot[31:27] != 5'd4) check_eq("alu_b", bus.alu_b, m_regs[m_slot[24:20]]);
    end
    @(posedge clk);
    #1;
    model_commit();
    cyc++;
  endtask

  // Emulated ALU: returns any job whose latency has elapsed, in random order; rare strays.
  task automatic pick_rsp();
    int due_idx[$];
    int k;
    d_rsp_valid = 1'b0; d_rsp_tag = '0; d_rsp_data = '0;
    if (!auto_alu) return;
    foreach (jobs[i]) if (jobs[i].due <= cyc) due_idx.push_back(i);
    if (due_idx.size() > 0 && $urandom_range(0, 1) == 1) begin
      k = due_idx[$urandom_range(0, due_idx.size() - 1)];
      d_rsp_valid = 1'b1;
      d_rsp_tag   = 5'(jobs[k].tag);
      d_rsp_data  = jobs[k].data;
      jobs.delete(k);
    end else if ($urandom_range(0, 39) == 0) begin
      d_rsp_valid = 1'b1;
      d_rsp_tag   = 5'($urandom_range(0, 31));
      d_rsp_data  = $urandom;
    end
  endtask

  task automatic gen_random();
    logic [31:0] w;
    int f;
    f = ($urandom_range(0, 9) != 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 31));
    w = enc(f, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    w[26:25] = 2'($urandom);
    w[14:12] = 3'($urandom);
    if ($urandom_range(0, 19) == 0) w[6:0] = 7'($urandom);
    d_rst       = ($urandom_range(0, 199) != 0);
    d_iv        = ($urandom_range(0, 9) < 7);
    d_instr     = w;
    d_load_en   = ($urandom_range(0, 9) == 0);
    d_load_addr = 5'($urandom_range(0, 7));
    d_load_data = $urandom;
    d_rready    = ($urandom_range(0, 3) != 0);
    pick_rsp();
  endtask

  initial begin
    logic [31:0] w;
    auto_alu = 1'b0;
    cyc      = 0;
    idle();
    d_rst = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_commit();

    check_eq("rst_instr_ready", bus.instr_ready, 1);
    check_eq("rst_req_valid", bus.alu_req_valid, 0);
    check_eq("rst_alu_op", bus.alu_op, 0);
    check_eq("rst_alu_a", bus.alu_a, 0);
    check_eq("rst_alu_b", bus.alu_b, 0);
    check_eq("rst_alu_tag", bus.alu_tag, 0);
    check_eq("rst_data_out", bus.data_out, 0);
    check_eq("rst_dout_valid", bus.data_out_valid, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_busy", bus.busy, 0);

    // Preload, add r3 = r1 + r2, writeback
    idle(); d_load_en = 1'b1; d_load_addr = 5'd1; d_load_data = 32'h3F800000; step();
    idle(); d_load_en = 1'b1; d_load_addr = 5'd2; d_load_data = 32'h40000000; step();
    idle(); d_iv = 1'b1; d_instr = enc(0, 3, 1, 2); step();
    check_eq("add_req_valid", bus.alu_req_valid, 1);
    check_eq("add_op", bus.alu_op, 0);
    check_eq("add_a", bus.alu_a, 32'h3F800000);
    check_eq("add_b", bus.alu_b, 32'h40000000);
    check_eq("add_tag", bus.alu_tag, 3);
    idle(); step();
    idle(); d_rsp_valid = 1'b1; d_rsp_tag = 5'd3; d_rsp_data = 32'h40400000; step();
    check_eq("add_dout_valid", bus.data_out_valid, 1);
    check_eq("add_data_out", bus.data_out, 32'h40400000);
    check_eq("add_busy", bus.busy, 0);
    idle(); d_iv = 1'b1; d_instr = enc(0, 8, 3, 0); step();
    check_eq("r3_readback", bus.alu_a, 32'h40400000);
    idle(); step();
    idle(); d_rsp_valid = 1'b1; d_rsp_tag = 5'd8; d_rsp_data = 32'h12345678; step();
    idle(); step();
    check_eq("pulse_drop", bus.data_out_valid, 0);

    // Illegal opcode, then out-of-range funct
    w = enc(0, 5, 1, 2);
    w[6:0] = 7'b0110011;
    idle(); d_iv = 1'b1; d_instr = w; step();
    check_eq("bad_opcode_err", bus.err, 1);
    check_eq("bad_opcode_req", bus.alu_req_valid, 0);
    idle(); d_iv = 1'b1; d_instr = enc(12, 5, 1, 2); step();
    check_eq("bad_funct_err", bus.err, 1);
    check_eq("bad_funct_req", bus.alu_req_valid, 0);
    check_eq("bad_funct_busy", bus.busy, 0);

    // ALU back-pressure holds request fields; stray response is flagged
    idle(); d_iv = 1'b1; d_instr = enc(2, 4, 1, 2); step();
    for (int i = 0; i < 4; i++) begin
      check_eq("stall_valid", bus.alu_req_valid, 1);
      check_eq("stall_op", bus.alu_op, 2);
      check_eq("stall_a", bus.alu_a, 32'h3F800000);
      check_eq("stall_b", bus.alu_b, 32'h40000000);
      check_eq("stall_tag", bus.alu_tag, 4);
      idle(); d_rready = 1'b0; step();
    end
    idle(); d_rready = 1'b0; d_rsp_valid = 1'b1; d_rsp_tag = 5'd9; d_rsp_data = 32'hDEADBEEF; step();
    check_eq("stray_err", bus.err, 1);
    check_eq("stray_no_wb", bus.data_out_valid, 0);
    idle(); step();
    idle(); d_rsp_valid = 1'b1; d_rsp_tag = 5'd4; d_rsp_data = 32'h41000000; step();
    idle(); d_iv = 1'b1; d_instr = enc(0, 10, 9, 4); step();
    check_eq("r9_unchanged", bus.alu_a, 0);
    check_eq("r4_written", bus.alu_b, 32'h41000000);
    idle(); step();
    idle(); d_rsp_valid = 1'b1; d_rsp_tag = 5'd10; d_rsp_data = 32'h0; step();
    idle(); step();

    // Randomized traffic with occasional mid-flight resets
    auto_alu = 1'b1;
    repeat (3000) begin
      gen_random();
      step();
    end

    // Drain outstanding work
    repeat (60) begin
      idle();
      pick_rsp();
      step();
    end
    check_eq("drain_busy", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
